mio_keypad: RTL and testbench
=============================

Name: mio_keypad

Overview:
- Memory-mapped input peripheral for a 4x4 hex keypad: the user-input counterpart of the seven-segment output driver.
- Drives active-low column strobes, samples active-low row returns, debounces, and decodes presses to 4-bit hex codes.
- Buffers codes in a small FIFO that the CPU pops over the MIO read bus.
- Sits beside mio_seg on the MIO bus; CPU-typed hex keys are typically echoed to the display.

Parameters:
- CLK_DIV, 4096: clk cycles per scan tick; minimum 4, which covers ROW synchroniser latency.
- DEBOUNCE_TICKS, 8: consecutive stable ticks required for a press and for a release; minimum 1.
- FIFO_DEPTH, 4: code buffer entries; fixed power of two, at most 7, so count fits 3 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ROW  in  4  keypad rows, active-low, pulled up externally, asynchronous to clk.
- COL  out  4  column strobes, active-low, one column driven at a time.
- rkey  in  1  read strobe, one clk cycle wide: pops the FIFO head and clears overflow.
- d_f_key  out  32  read data: [31] not-empty, [30] overflow, [18:16] count, [3:0] head code; all other bits 0.
- key_valid  out  1  equals d_f_key[31].

Behaviour:
- Reset state, asynchronous assert and synchronous-clean release:
  - COL=4'b1110, col_idx=0, tick counter=0, FSM=SCAN, FIFO empty, overflow=0.
  - Synchroniser flops=4'hF, so d_f_key=0 and key_valid=0.
- Asserting reset mid-operation discards any in-progress debounce and all FIFO contents.
- ROW passes through a 2-flop synchroniser (rows_s) and is used only at scan ticks.
- Tick: the counter runs 0..CLK_DIV-1; tick=1 for one cycle when the counter equals CLK_DIV-1, then it wraps to 0.
- FSM, evaluated only on tick:
  - SCAN:
    - rows_s==4'hF: col_idx increments mod 4; COL=~(1<<col_idx) takes the new value at that edge.
    - Exactly one row low: latch row_idx and col_idx, hold the column, stable_cnt=1, go to DEBOUNCE.
    - Two or more rows low (ghost/multi-key): ignore and advance the column as if idle.
  - DEBOUNCE:
    - rows_s equals the latched one-hot pattern: stable_cnt++; when it reaches DEBOUNCE_TICKS, push the code and go to HELD.
    - Any other rows_s: go to SCAN without a push; the column is not advanced on this tick.
  - HELD:
    - rows_s==4'hF increments rel_cnt; anything else clears rel_cnt.
    - rel_cnt reaching DEBOUNCE_TICKS: go to SCAN and advance the column.
    - A held key produces exactly one push, with no auto-repeat.
- With DEBOUNCE_TICKS=1, the push happens on the detecting tick itself; the FSM goes from SCAN directly to HELD.
- Key map, code = f(row,col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- FIFO:
  - Push writes the tail. Pop (rkey && !empty) advances the head at the same edge.
  - d_f_key is combinational from registered state, so it reflects a pop on the cycle after the rkey edge.
- FIFO boundary cases:
  - Push while full with no pop: the code is dropped and overflow is set.
  - Push and pop in the same cycle: both happen and count is unchanged. This includes the full case, where the push is accepted and overflow is not set.
  - rkey on empty: no pop, no count change, overflow cleared.
  - rkey in the same cycle as a new overflow: overflow stays set, because set wins.
- The count field is exact, 0..FIFO_DEPTH; the head-code field reads 0 when the FIFO is empty.

Decomposition:
- Shared package mio_keypad_pkg:
  - FSM state enum {SCAN, DEBOUNCE, HELD}.
  - 16-entry key-code ROM constant indexed by {row_idx,col_idx}.
  - d_f_key bit-position constants.
- Sub-module key_fifo:
  - Generic synchronous FIFO with push, pop, full, empty, count and async active-low reset.
  - Width 4, depth FIFO_DEPTH.

Test Plan (CLK_DIV=4, DEBOUNCE_TICKS=3):
- Reset with ROW=F, no activity -> d_f_key=32'h0; COL cycles E,D,B,7,E every 4 clk cycles.
- Hold row1 low while COL=4'b1011 (col2), steady 5 ticks -> exactly one push, d_f_key=32'h8001_0006; COL frozen at 4'b1011 until release plus 3 high ticks.
- Rows bounce low/high/low during DEBOUNCE on col0 row0 -> no push, d_f_key stays 0; a later steady press pushes 32'h8001_0001.
- Rows 0 and 2 low together on col1 -> no push, scanning continues uninterrupted.
- Press '1','2','3','A','5' without reading -> d_f_key=32'hC004_0001; after 4 rkey pulses -> 32'h0 (overflow cleared by the first read).
- Pop pulse coinciding with the push edge when count=4 -> count stays 4 with no overflow. Separately, assert rst_n low during DEBOUNCE -> all outputs back to reset values immediately.

Source files
------------

// File: rtl/mio_keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad peripheral.
package mio_keypad_pkg;

    // Scan FSM states.
    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld
    } kp_state_e;

    // Key codes indexed by {row_idx, col_idx}; entry 0 is row0/col0.
    localparam logic [15:0][3:0] KeyRom = {
        4'hD, 4'hF, 4'h0, 4'hE,   // row3: * 0 # D
        4'hC, 4'h9, 4'h8, 4'h7,   // row2
        4'hB, 4'h6, 4'h5, 4'h4,   // row1
        4'hA, 4'h3, 4'h2, 4'h1    // row0
    };

    // Read-data field positions.
    localparam int unsigned DfNotEmptyBit = 31;
    localparam int unsigned DfOverflowBit = 30;
    localparam int unsigned DfCountLsb    = 16;
    localparam int unsigned DfCountWidth  = 3;
    localparam int unsigned DfCodeLsb     = 0;

    // True when exactly one active-low row is asserted.
    function automatic logic single_low(input logic [3:0] rows);
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Index of the single low row; only meaningful when single_low() holds.
    function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
        case (rows)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mio_keypad_fifo.sv
// Generic synchronous FIFO with exact occupancy count; a push while full is
// accepted only when a pop happens in the same cycle.
module key_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mio_keypad.sv
// 4x4 hex keypad scanner: column strobing, row synchronisation, press and
// release debounce, key decode and a small code FIFO read over the MIO bus.
module mio_keypad
    import mio_keypad_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 4096,
    parameter int unsigned DEBOUNCE_TICKS = 8,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ROW,
    output logic [3:0]  COL,
    input  logic        rkey,
    output logic [31:0] d_f_key,
    output logic        key_valid
);

    localparam int unsigned TickW    = $clog2(CLK_DIV);
    localparam int unsigned DbW      = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [TickW-1:0] TickLast = TickW'(CLK_DIV - 1);
    localparam logic [DbW-1:0]   DbTarget = DbW'(DEBOUNCE_TICKS);

    logic [3:0]          row_meta_q;
    logic [3:0]          rows_s_q;
    logic [TickW-1:0]    tick_cnt_q;
    logic                tick;

    kp_state_e           state_q, state_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [1:0]          row_idx_q, row_idx_d;
    logic [DbW-1:0]      stable_cnt_q, stable_cnt_d;
    logic [DbW-1:0]      rel_cnt_q, rel_cnt_d;
    logic [3:0]          held_pattern;
    logic [1:0]          det_row;

    logic                push;
    logic [3:0]          push_code;
    logic [3:0]          head_code;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FifoCntW-1:0] fifo_count;
    logic                ovf_q, ovf_d;

    // Two-flop synchroniser for the asynchronous row returns; idle is all-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'hF;
            rows_s_q   <= 4'hF;
        end else begin
            row_meta_q <= ROW;
            rows_s_q   <= row_meta_q;
        end
    end

    assign tick = (tick_cnt_q == TickLast);

    // Free-running scan prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
        end
    end

    assign held_pattern = ~(4'b0001 << row_idx_q);
    assign det_row      = low_row_idx(rows_s_q);

    // Scan/debounce/held transitions; only a tick can move the FSM.
    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        row_idx_d    = row_idx_q;
        stable_cnt_d = stable_cnt_q;
        rel_cnt_d    = rel_cnt_q;
        push         = 1'b0;
        push_code    = KeyRom[{row_idx_q, col_idx_q}];
        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (single_low(rows_s_q)) begin
                        row_idx_d    = det_row;
                        stable_cnt_d = DbW'(1);
                        if (DbTarget == DbW'(1)) begin
                            // A single stable sample is already enough.
                            push      = 1'b1;
                            push_code = KeyRom[{det_row, col_idx_q}];
                            rel_cnt_d = '0;
                            state_d   = StHeld;
                        end else begin
                            state_d = StDebounce;
                        end
                    end else begin
                        // Idle or ghosted multi-row reads both keep scanning.
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                StDebounce: begin
                    if (rows_s_q == held_pattern) begin
                        stable_cnt_d = stable_cnt_q + DbW'(1);
                        if (stable_cnt_d == DbTarget) begin
                            push      = 1'b1;
                            rel_cnt_d = '0;
                            state_d   = StHeld;
                        end
                    end else begin
                        // Bounce: rescan the same column on the next tick.
                        state_d = StScan;
                    end
                end
                StHeld: begin
                    if (rows_s_q == 4'hF) begin
                        rel_cnt_d = rel_cnt_q + DbW'(1);
                        if (rel_cnt_d == DbTarget) begin
                            state_d   = StScan;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    // Scan FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StScan;
            col_idx_q    <= 2'd0;
            row_idx_q    <= 2'd0;
            stable_cnt_q <= '0;
            rel_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            col_idx_q    <= col_idx_d;
            row_idx_q    <= row_idx_d;
            stable_cnt_q <= stable_cnt_d;
            rel_cnt_q    <= rel_cnt_d;
        end
    end

    assign COL = ~(4'b0001 << col_idx_q);

    key_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_code),
        .pop   (rkey),
        .rdata (head_code),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A dropped push sets overflow and wins over the clear from a read.
    always_comb begin
        ovf_d = ovf_q;
        if (rkey) ovf_d = 1'b0;
        if (push && fifo_full && !rkey) ovf_d = 1'b1;
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Read-data word assembly.
    always_comb begin
        d_f_key                               = '0;
        d_f_key[DfNotEmptyBit]                = !fifo_empty;
        d_f_key[DfOverflowBit]                = ovf_q;
        d_f_key[DfCountLsb +: DfCountWidth]   = DfCountWidth'(fifo_count);
        d_f_key[DfCodeLsb +: 4]               = head_code;
    end

    assign key_valid = !fifo_empty;

endmodule

// File: tb/tb_mio_keypad.sv
// Self-checking bench for mio_keypad with a combinational keypad matrix model.
module tb_mio_keypad;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DB      = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic        rkey;
    logic [31:0] d_f_key;
    logic        key_valid;

    logic [15:0] pressed;
    logic        force_en;
    logic [3:0]  force_rows;
    logic [3:0]  row_low;

    int nvec = 0;
    int nerr = 0;

    // Reference FIFO contents and overflow flag.
    logic [3:0] mq[$];
    bit         m_ovf;

    typedef struct {
        int          r;
        int          c;
        logic [31:0] exp_word;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        row_low = 4'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !COL[c]) row_low[r] = 1'b1;
        ROW = force_en ? force_rows : ~row_low;
    end

    mio_keypad #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_TICKS (DB),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ROW       (ROW),
        .COL       (COL),
        .rkey      (rkey),
        .d_f_key   (d_f_key),
        .key_valid (key_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rkey();
        rkey = 1'b1;
        clks(1);
        rkey = 1'b0;
    endtask

    // Returns at the cycle right after COL switches to target.
    task automatic wait_col(input logic [3:0] target);
        int n = 0;
        while (COL == target && n < 64) begin clks(1); n++; end
        while (COL != target && n < 64) begin clks(1); n++; end
        check("wait_col", {28'h0, COL}, {28'h0, target});
    endtask

    task automatic press_key(input int r, input int c);
        pressed[r*4+c] = 1'b1;
        clks(14 * CLK_DIV);
        pressed = '0;
        clks(10 * CLK_DIV);
    endtask

    function automatic logic [3:0] code_of(input int r, input int c);
        case (r * 4 + c)
            0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
            4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
            8: return 4'h7;  9: return 4'h8;  10: return 4'h9; 11: return 4'hC;
            12: return 4'hE; 13: return 4'h0; 14: return 4'hF; default: return 4'hD;
        endcase
    endfunction

    function automatic logic [31:0] model_word();
        logic [31:0] w = '0;
        w[31]    = (mq.size() != 0);
        w[30]    = m_ovf;
        w[18:16] = 3'(mq.size());
        if (mq.size() != 0) w[3:0] = mq[0];
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] col_seq [4];
        col_seq = '{4'hD, 4'hB, 4'h7, 4'hE};
        tbl[0]  = '{0, 0, 32'h8001_0001}; tbl[1]  = '{0, 1, 32'h8001_0002};
        tbl[2]  = '{0, 2, 32'h8001_0003}; tbl[3]  = '{0, 3, 32'h8001_000A};
        tbl[4]  = '{1, 0, 32'h8001_0004}; tbl[5]  = '{1, 1, 32'h8001_0005};
        tbl[6]  = '{1, 2, 32'h8001_0006}; tbl[7]  = '{1, 3, 32'h8001_000B};
        tbl[8]  = '{2, 0, 32'h8001_0007}; tbl[9]  = '{2, 1, 32'h8001_0008};
        tbl[10] = '{2, 2, 32'h8001_0009}; tbl[11] = '{2, 3, 32'h8001_000C};
        tbl[12] = '{3, 0, 32'h8001_000E}; tbl[13] = '{3, 1, 32'h8001_0000};
        tbl[14] = '{3, 2, 32'h8001_000F}; tbl[15] = '{3, 3, 32'h8001_000D};

        rst_n = 1'b0; rkey = 1'b0; pressed = '0; force_en = 1'b0; force_rows = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("reset d_f_key", d_f_key, 32'h0);
        check("reset key_valid", {31'h0, key_valid}, 32'h0);
        check("reset COL", {28'h0, COL}, 32'hE);

        // Idle column rotation.
        @(negedge clk);
        rst_n = 1'b1;
        check("idle COL start", {28'h0, COL}, 32'hE);
        for (int k = 0; k < 4; k++) begin
            clks(4);
            check("idle COL rotate", {28'h0, COL}, {28'h0, col_seq[k]});
        end
        check("idle d_f_key", d_f_key, 32'h0);

        // Key '6' held on col2: one push, column frozen until release debounced.
        wait_col(4'hB);
        pressed[1*4+2] = 1'b1;
        clks(5 * CLK_DIV);
        check("held push", d_f_key, 32'h8001_0006);
        check("held COL", {28'h0, COL}, 32'hB);
        clks(10 * CLK_DIV);
        check("no repeat", d_f_key, 32'h8001_0006);
        check("held COL late", {28'h0, COL}, 32'hB);
        pressed = '0;
        clks(2 * CLK_DIV);
        check("release COL held", {28'h0, COL}, 32'hB);
        clks(CLK_DIV);
        check("release COL adv", {28'h0, COL}, 32'h7);
        pulse_rkey();
        check("pop to empty", d_f_key, 32'h0);

        // Bounce during debounce on col0/row0.
        wait_col(4'hE);
        force_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            force_rows = (k % 2 == 0) ? 4'b1110 : 4'b1111;
            clks(CLK_DIV);
        end
        force_en = 1'b0;
        check("bounce no push", d_f_key, 32'h0);
        check("bounce COL kept", {28'h0, COL}, 32'hE);
        press_key(0, 0);
        check("steady '1'", d_f_key, 32'h8001_0001);
        pulse_rkey();

        // Ghost: rows 0 and 2 on col1 must not stall the scan.
        wait_col(4'hD);
        pressed[0*4+1] = 1'b1;
        pressed[2*4+1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            clks(CLK_DIV);
            check("ghost COL", {28'h0, COL}, {28'h0, col_seq[(k + 1) % 4]});
        end
        pressed = '0;
        check("ghost no push", d_f_key, 32'h0);

        // Overflow and draining.
        press_key(0, 0); press_key(0, 1); press_key(0, 2); press_key(0, 3); press_key(1, 1);
        check("overflow word", d_f_key, 32'hC004_0001);
        pulse_rkey(); check("drain 1", d_f_key, 32'h8003_0002);
        pulse_rkey(); check("drain 2", d_f_key, 32'h8002_0003);
        pulse_rkey(); check("drain 3", d_f_key, 32'h8001_000A);
        pulse_rkey(); check("drain 4", d_f_key, 32'h0);
        pulse_rkey(); check("rkey on empty", d_f_key, 32'h0);

        // Pop coinciding with the push edge while full.
        press_key(0, 0); press_key(0, 1); press_key(0, 2); press_key(0, 3);
        wait_col(4'hD);
        pressed[1*4+1] = 1'b1;
        clks(3 * CLK_DIV - 1);
        rkey = 1'b1;
        clks(1);
        rkey = 1'b0;
        check("push+pop full", d_f_key, 32'h8004_0002);
        clks(4 * CLK_DIV);
        pressed = '0;
        clks(10 * CLK_DIV);
        pulse_rkey(); check("after swap 1", d_f_key, 32'h8003_0003);
        pulse_rkey(); check("after swap 2", d_f_key, 32'h8002_000A);
        pulse_rkey(); check("after swap 3", d_f_key, 32'h8001_0005);
        pulse_rkey(); check("after swap 4", d_f_key, 32'h0);

        // Reset asserted mid-debounce with one code buffered.
        press_key(2, 0);
        check("pre-reset word", d_f_key, 32'h8001_0007);
        wait_col(4'hE);
        pressed[1*4+0] = 1'b1;
        clks(CLK_DIV + 2);
        #2 rst_n = 1'b0;
        #1;
        check("async rst d_f_key", d_f_key, 32'h0);
        check("async rst valid", {31'h0, key_valid}, 32'h0);
        check("async rst COL", {28'h0, COL}, 32'hE);
        pressed = '0;
        @(negedge clk);
        rst_n = 1'b1;
        clks(2);
        check("post-reset word", d_f_key, 32'h0);

        // Table: every key position decodes to its code.
        for (int i = 0; i < 16; i++) begin
            press_key(tbl[i].r, tbl[i].c);
            check($sformatf("table key r%0d c%0d", tbl[i].r, tbl[i].c), d_f_key, tbl[i].exp_word);
            pulse_rkey();
            check("table pop", d_f_key, 32'h0);
        end

        // Random presses and reads against the queue model.
        mq.delete();
        m_ovf = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                int r = $urandom_range(0, 3);
                int c = $urandom_range(0, 3);
                press_key(r, c);
                if (mq.size() < 4) mq.push_back(code_of(r, c));
                else m_ovf = 1'b1;
            end else begin
                pulse_rkey();
                if (mq.size() != 0) void'(mq.pop_front());
                m_ovf = 1'b0;
            end
            check("random word", d_f_key, model_word());
            check("random valid", {31'h0, key_valid}, {31'h0, mq.size() != 0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
